// File: rtl/c7bbiu_rd_arb.sv
// c7bbiu_rd_arb
// Read-channel arbiter of the BIU. Shares one AXI AR/R channel between the
// IFU and LSU read requesters, with one outstanding read at a time. When both
// request together, the requester that was not granted last wins. An IFU
// cancel marks the in-flight fetch as dropped. The AXI handshake still
// completes, and its response is consumed without being reported.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   ifu_biu_rd_req/addr      IFU read request and address (held until ack)
//   ifu_biu_cancel           IFU cancels its pending or in-flight fetch
//   biu_ifu_rd_ack           pulse: IFU request accepted on AR
//   biu_ifu_data_valid/data/rd_err   IFU read return (err qualifies valid)
//   lsu_biu_rd_req/addr      LSU read request and address
//   biu_lsu_rd_ack/data_valid/data/rd_err   LSU counterparts
//   biu_ext_ar_*/ext_biu_ar_ready   AXI read address channel
//   ext_biu_r_*/biu_ext_r_ready     AXI read data channel
module c7bbiu_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int IFU_ID = 0,
  parameter int LSU_ID = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ifu_biu_rd_req,
  input  logic [ADDR_W-1:0] ifu_biu_rd_addr,
  input  logic              ifu_biu_cancel,
  output logic              biu_ifu_rd_ack,
  output logic              biu_ifu_data_valid,
  output logic [DATA_W-1:0] biu_ifu_data,
  output logic              biu_ifu_rd_err,
  input  logic              lsu_biu_rd_req,
  input  logic [ADDR_W-1:0] lsu_biu_rd_addr,
  output logic              biu_lsu_rd_ack,
  output logic              biu_lsu_data_valid,
  output logic [DATA_W-1:0] biu_lsu_data,
  output logic              biu_lsu_rd_err,
  output logic              biu_ext_ar_valid,
  input  logic              ext_biu_ar_ready,
  output logic [ID_W-1:0]   biu_ext_ar_id,
  output logic [ADDR_W-1:0] biu_ext_ar_addr,
  output logic [7:0]        biu_ext_ar_len,
  output logic [2:0]        biu_ext_ar_size,
  output logic [1:0]        biu_ext_ar_burst,
  input  logic              ext_biu_r_valid,
  output logic              biu_ext_r_ready,
  input  logic [ID_W-1:0]   ext_biu_r_id,
  input  logic [DATA_W-1:0] ext_biu_r_data,
  input  logic              ext_biu_r_last,
  input  logic [1:0]        ext_biu_r_resp
);

  localparam logic [ID_W-1:0] IFU_ID_L = ID_W'(IFU_ID);
  localparam logic [ID_W-1:0] LSU_ID_L = ID_W'(LSU_ID);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;  // 0 = IFU, 1 = LSU
  logic              owner_reg, owner_next;            // 0 = IFU, 1 = LSU
  logic              drop_reg, drop_next;
  logic [ADDR_W-1:0] ar_addr_reg, ar_addr_next;
  logic [ID_W-1:0]   ar_id_reg, ar_id_next;
  logic              ifu_dv_reg, ifu_dv_next, lsu_dv_reg, lsu_dv_next;
  logic              ifu_err_reg, ifu_err_next, lsu_err_reg, lsu_err_next;
  logic [DATA_W-1:0] ifu_data_reg, ifu_data_next, lsu_data_reg, lsu_data_next;

  logic ifu_elig, lsu_elig, grant_lsu, ifu_cancel_hit, ar_hs, r_done;

  // A cancelling IFU is not eligible. On a tie the requester that was not
  // granted last wins.
  assign ifu_elig       = ifu_biu_rd_req & ~ifu_biu_cancel;
  assign lsu_elig       = lsu_biu_rd_req;
  assign grant_lsu      = lsu_elig & (~ifu_elig | ~last_grant_reg);
  assign ifu_cancel_hit = ~owner_reg & ifu_biu_cancel;
  assign ar_hs          = (state_reg == S_AR) & ext_biu_ar_ready;
  assign r_done         = (state_reg == S_R) & ext_biu_r_valid &
                          (ext_biu_r_id == ar_id_reg) & ext_biu_r_last;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    drop_next       = drop_reg;
    ar_addr_next    = ar_addr_reg;
    ar_id_next      = ar_id_reg;
    ifu_dv_next     = 1'b0;
    lsu_dv_next     = 1'b0;
    ifu_err_next    = 1'b0;
    lsu_err_next    = 1'b0;
    ifu_data_next   = ifu_data_reg;
    lsu_data_next   = lsu_data_reg;
    case (state_reg)
      S_IDLE: begin
        if (ifu_elig | lsu_elig) begin
          owner_next      = grant_lsu;
          last_grant_next = grant_lsu;
          ar_addr_next    = grant_lsu ? lsu_biu_rd_addr : ifu_biu_rd_addr;
          ar_id_next      = grant_lsu ? LSU_ID_L : IFU_ID_L;
          drop_next       = 1'b0;
          state_next      = S_AR;
        end
      end
      S_AR: begin
        // The AR request cannot be retracted, so a cancel only marks it.
        if (ifu_cancel_hit) drop_next = 1'b1;
        if (ext_biu_ar_ready) state_next = S_R;
      end
      S_R: begin
        if (ifu_cancel_hit) drop_next = 1'b1;
        // Beats with a foreign ID are accepted and ignored.
        if (r_done) begin
          state_next = S_IDLE;
          if (owner_reg) begin
            lsu_dv_next   = 1'b1;
            lsu_err_next  = (ext_biu_r_resp != 2'b00);
            lsu_data_next = ext_biu_r_data;
          end else begin
            ifu_dv_next   = ~(drop_reg | ifu_biu_cancel);
            ifu_err_next  = ~(drop_reg | ifu_biu_cancel) & (ext_biu_r_resp != 2'b00);
            ifu_data_next = ext_biu_r_data;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      drop_reg       <= 1'b0;
      ar_addr_reg    <= '0;
      ar_id_reg      <= '0;
      ifu_dv_reg     <= 1'b0;
      lsu_dv_reg     <= 1'b0;
      ifu_err_reg    <= 1'b0;
      lsu_err_reg    <= 1'b0;
      ifu_data_reg   <= '0;
      lsu_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      drop_reg       <= drop_next;
      ar_addr_reg    <= ar_addr_next;
      ar_id_reg      <= ar_id_next;
      ifu_dv_reg     <= ifu_dv_next;
      lsu_dv_reg     <= lsu_dv_next;
      ifu_err_reg    <= ifu_err_next;
      lsu_err_reg    <= lsu_err_next;
      ifu_data_reg   <= ifu_data_next;
      lsu_data_reg   <= lsu_data_next;
    end
  end

  // The ack is combinational on the handshake. A drop or a same-cycle IFU
  // cancel suppresses it.
  assign biu_ifu_rd_ack     = ar_hs & ~owner_reg & ~drop_reg & ~ifu_biu_cancel;
  assign biu_lsu_rd_ack     = ar_hs & owner_reg & ~drop_reg;
  assign biu_ifu_data_valid = ifu_dv_reg;
  assign biu_ifu_data       = ifu_data_reg;
  assign biu_ifu_rd_err     = ifu_err_reg;
  assign biu_lsu_data_valid = lsu_dv_reg;
  assign biu_lsu_data       = lsu_data_reg;
  assign biu_lsu_rd_err     = lsu_err_reg;

  assign biu_ext_ar_valid   = (state_reg == S_AR);
  assign biu_ext_ar_id      = ar_id_reg;
  assign biu_ext_ar_addr    = ar_addr_reg;
  assign biu_ext_ar_len     = 8'd0;
  assign biu_ext_ar_size    = 3'b010;
  assign biu_ext_ar_burst   = 2'b01;
  assign biu_ext_r_ready    = (state_reg == S_R);

endmodule

// File: tb/tb_c7bbiu_rd_arb.sv
// Testbench for c7bbiu_rd_arb. A cycle driver models both requesters and an
// AXI slave, and it records what the DUT does into observation queues. Each
// test task pushes its expected AR/data results and compares them against
// the observations.
module tb_c7bbiu_rd_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              ifu_biu_rd_req = 1'b0, ifu_biu_cancel = 1'b0;
  logic [ADDR_W-1:0] ifu_biu_rd_addr = '0;
  logic              lsu_biu_rd_req = 1'b0;
  logic [ADDR_W-1:0] lsu_biu_rd_addr = '0;
  logic              biu_ifu_rd_ack, biu_ifu_data_valid, biu_ifu_rd_err;
  logic              biu_lsu_rd_ack, biu_lsu_data_valid, biu_lsu_rd_err;
  logic [DATA_W-1:0] biu_ifu_data, biu_lsu_data;
  logic              biu_ext_ar_valid, biu_ext_r_ready;
  logic              ext_biu_ar_ready = 1'b0;
  logic [ID_W-1:0]   biu_ext_ar_id;
  logic [ADDR_W-1:0] biu_ext_ar_addr;
  logic [7:0]        biu_ext_ar_len;
  logic [2:0]        biu_ext_ar_size;
  logic [1:0]        biu_ext_ar_burst;
  logic              ext_biu_r_valid = 1'b0, ext_biu_r_last = 1'b0;
  logic [ID_W-1:0]   ext_biu_r_id = '0;
  logic [DATA_W-1:0] ext_biu_r_data = '0;
  logic [1:0]        ext_biu_r_resp = '0;

  c7bbiu_rd_arb dut (
    .clk(clk), .resetn(resetn),
    .ifu_biu_rd_req(ifu_biu_rd_req), .ifu_biu_rd_addr(ifu_biu_rd_addr),
    .ifu_biu_cancel(ifu_biu_cancel), .biu_ifu_rd_ack(biu_ifu_rd_ack),
    .biu_ifu_data_valid(biu_ifu_data_valid), .biu_ifu_data(biu_ifu_data),
    .biu_ifu_rd_err(biu_ifu_rd_err),
    .lsu_biu_rd_req(lsu_biu_rd_req), .lsu_biu_rd_addr(lsu_biu_rd_addr),
    .biu_lsu_rd_ack(biu_lsu_rd_ack), .biu_lsu_data_valid(biu_lsu_data_valid),
    .biu_lsu_data(biu_lsu_data), .biu_lsu_rd_err(biu_lsu_rd_err),
    .biu_ext_ar_valid(biu_ext_ar_valid), .ext_biu_ar_ready(ext_biu_ar_ready),
    .biu_ext_ar_id(biu_ext_ar_id), .biu_ext_ar_addr(biu_ext_ar_addr),
    .biu_ext_ar_len(biu_ext_ar_len), .biu_ext_ar_size(biu_ext_ar_size),
    .biu_ext_ar_burst(biu_ext_ar_burst),
    .ext_biu_r_valid(ext_biu_r_valid), .biu_ext_r_ready(biu_ext_r_ready),
    .ext_biu_r_id(ext_biu_r_id), .ext_biu_r_data(ext_biu_r_data),
    .ext_biu_r_last(ext_biu_r_last), .ext_biu_r_resp(ext_biu_r_resp)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Driver / slave model state
  int cyc = 0;
  int ar_ready_delay = 0, r_lat = 1, ar_wait_cnt = 0, r_cnt = 0;
  bit r_pend = 0, cancel_after_ack = 0, cancel_now = 0, lsu_late_valid = 0;
  logic [ADDR_W-1:0] lsu_late_addr = '0;
  logic [DATA_W-1:0] r_cur_data = '0;
  logic [1:0]        r_cur_resp = '0;
  logic [ID_W-1:0]   r_cur_id = '0;
  logic [ADDR_W-1:0] ifu_addr_q[$], lsu_addr_q[$];
  logic [DATA_W-1:0] resp_data_q[$];
  logic [1:0]        resp_resp_q[$];

  // Scoreboard: expected
  logic [ADDR_W-1:0] exp_ar_addr_q[$];
  logic [ID_W-1:0]   exp_ar_id_q[$];
  logic [DATA_W-1:0] exp_ifu_data_q[$], exp_lsu_data_q[$];
  logic              exp_ifu_err_q[$], exp_lsu_err_q[$];

  // Observations
  logic [ADDR_W-1:0] obs_ar_addr_q[$];
  logic [ID_W-1:0]   obs_ar_id_q[$];
  int                obs_ar_cyc_q[$], obs_hs_cyc_q[$], obs_beat_cyc_q[$];
  int                obs_ifu_ack_cyc_q[$], obs_lsu_ack_cyc_q[$];
  logic [DATA_W-1:0] obs_ifu_data_q[$], obs_lsu_data_q[$];
  logic              obs_ifu_err_q[$], obs_lsu_err_q[$];
  int                obs_ifu_dv_cyc_q[$], obs_lsu_dv_cyc_q[$];
  int                dual_cnt = 0, unstable_cnt = 0, bad_ack_cnt = 0;
  logic              prev_valid = 0, prev_hs = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [ID_W-1:0]   prev_id = '0;

  task automatic clear_all();
    ifu_addr_q.delete(); lsu_addr_q.delete(); resp_data_q.delete(); resp_resp_q.delete();
    exp_ar_addr_q.delete(); exp_ar_id_q.delete();
    exp_ifu_data_q.delete(); exp_ifu_err_q.delete(); exp_lsu_data_q.delete(); exp_lsu_err_q.delete();
    obs_ar_addr_q.delete(); obs_ar_id_q.delete(); obs_ar_cyc_q.delete(); obs_hs_cyc_q.delete();
    obs_beat_cyc_q.delete(); obs_ifu_ack_cyc_q.delete(); obs_lsu_ack_cyc_q.delete();
    obs_ifu_data_q.delete(); obs_ifu_err_q.delete(); obs_ifu_dv_cyc_q.delete();
    obs_lsu_data_q.delete(); obs_lsu_err_q.delete(); obs_lsu_dv_cyc_q.delete();
    dual_cnt = 0; unstable_cnt = 0; bad_ack_cnt = 0;
    prev_valid = 0; prev_hs = 0; ar_wait_cnt = 0; r_pend = 0;
    cancel_after_ack = 0; cancel_now = 0; lsu_late_valid = 0;
    ar_ready_delay = 0; r_lat = 1;
  endtask

  task automatic idle_inputs();
    ifu_biu_rd_req = 0; ifu_biu_rd_addr = '0; ifu_biu_cancel = 0;
    lsu_biu_rd_req = 0; lsu_biu_rd_addr = '0; ext_biu_ar_ready = 0;
    ext_biu_r_valid = 0; ext_biu_r_last = 0; ext_biu_r_id = '0;
    ext_biu_r_data = '0; ext_biu_r_resp = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    clear_all();
  endtask

  // One negedge per cycle: drive the inputs, wait #1, then observe the DUT.
  task automatic run_bus(input int ncycles);
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      cyc++;
      ext_biu_ar_ready = (ar_wait_cnt >= ar_ready_delay);
      ifu_biu_rd_req   = (ifu_addr_q.size() != 0);
      ifu_biu_rd_addr  = ifu_biu_rd_req ? ifu_addr_q[0] : '0;
      lsu_biu_rd_req   = (lsu_addr_q.size() != 0);
      lsu_biu_rd_addr  = lsu_biu_rd_req ? lsu_addr_q[0] : '0;
      ifu_biu_cancel   = cancel_now;
      cancel_now       = 0;
      ext_biu_r_valid = 0; ext_biu_r_last = 0; ext_biu_r_id = '0;
      ext_biu_r_data = '0; ext_biu_r_resp = '0;
      if (r_pend) begin
        if (r_cnt == 0) begin
          ext_biu_r_valid = 1; ext_biu_r_last = 1; ext_biu_r_id = r_cur_id;
          ext_biu_r_data = r_cur_data; ext_biu_r_resp = r_cur_resp;
        end else r_cnt--;
      end
      #1;
      if (biu_ext_ar_valid) begin
        if (!(prev_valid && !prev_hs)) obs_ar_cyc_q.push_back(cyc);
        else if (biu_ext_ar_addr != prev_addr || biu_ext_ar_id != prev_id) unstable_cnt++;
        if (ext_biu_ar_ready) begin
          obs_ar_addr_q.push_back(biu_ext_ar_addr);
          obs_ar_id_q.push_back(biu_ext_ar_id);
          obs_hs_cyc_q.push_back(cyc);
          ar_wait_cnt = 0; r_pend = 1; r_cnt = r_lat; r_cur_id = biu_ext_ar_id;
          r_cur_data = (resp_data_q.size() != 0) ? resp_data_q.pop_front() : '0;
          r_cur_resp = (resp_resp_q.size() != 0) ? resp_resp_q.pop_front() : 2'b00;
        end else ar_wait_cnt++;
      end else if (prev_valid && !prev_hs) unstable_cnt++;
      prev_valid = biu_ext_ar_valid;
      prev_hs    = biu_ext_ar_valid & ext_biu_ar_ready;
      prev_addr  = biu_ext_ar_addr;
      prev_id    = biu_ext_ar_id;
      if (biu_ifu_rd_ack) begin
        obs_ifu_ack_cyc_q.push_back(cyc);
        if (!(biu_ext_ar_valid && ext_biu_ar_ready)) bad_ack_cnt++;
        if (ifu_addr_q.size() != 0) void'(ifu_addr_q.pop_front());
        if (cancel_after_ack) begin
          cancel_now = 1; cancel_after_ack = 0;
          if (lsu_late_valid) begin lsu_addr_q.push_back(lsu_late_addr); lsu_late_valid = 0; end
        end
      end
      if (biu_lsu_rd_ack) begin
        obs_lsu_ack_cyc_q.push_back(cyc);
        if (!(biu_ext_ar_valid && ext_biu_ar_ready)) bad_ack_cnt++;
        if (lsu_addr_q.size() != 0) void'(lsu_addr_q.pop_front());
      end
      if (biu_ifu_rd_ack && biu_lsu_rd_ack) dual_cnt++;
      if (biu_ifu_data_valid && biu_lsu_data_valid) dual_cnt++;
      if (biu_ifu_data_valid) begin
        obs_ifu_data_q.push_back(biu_ifu_data); obs_ifu_err_q.push_back(biu_ifu_rd_err);
        obs_ifu_dv_cyc_q.push_back(cyc);
      end
      if (biu_lsu_data_valid) begin
        obs_lsu_data_q.push_back(biu_lsu_data); obs_lsu_err_q.push_back(biu_lsu_rd_err);
        obs_lsu_dv_cyc_q.push_back(cyc);
      end
      if (ext_biu_r_valid && biu_ext_r_ready) begin
        r_pend = 0; obs_beat_cyc_q.push_back(cyc);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    tests_run++;
    if ({biu_ext_ar_valid, biu_ext_r_ready, biu_ifu_rd_ack, biu_lsu_rd_ack,
         biu_ifu_data_valid, biu_lsu_data_valid, biu_ifu_rd_err, biu_lsu_rd_err} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 00000000", {biu_ext_ar_valid, biu_ext_r_ready,
               biu_ifu_rd_ack, biu_lsu_rd_ack, biu_ifu_data_valid, biu_lsu_data_valid,
               biu_ifu_rd_err, biu_lsu_rd_err});
    end
    tests_run++;
    if (biu_ext_ar_addr !== '0 || biu_ext_ar_id !== '0 || biu_ifu_data !== '0 || biu_lsu_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h id=%h ifu=%h lsu=%h required all zero",
               biu_ext_ar_addr, biu_ext_ar_id, biu_ifu_data, biu_lsu_data);
    end
    tests_run++;
    if (biu_ext_ar_len !== 8'd0 || biu_ext_ar_size !== 3'b010 || biu_ext_ar_burst !== 2'b01) begin
      tests_failed++;
      $display("FAIL ar_const: len=%h size=%b burst=%b required 00/010/01",
               biu_ext_ar_len, biu_ext_ar_size, biu_ext_ar_burst);
    end
    $display("[TB] reset checked");
    resetn = 1;
    clear_all();
  endtask

  task automatic test_ifu_only();
    int start;
    clear_all();
    r_lat = 2;
    ifu_addr_q.push_back(32'h1C00_0000);
    resp_data_q.push_back(32'hDEAD_BEEF); resp_resp_q.push_back(2'b00);
    exp_ar_addr_q.push_back(32'h1C00_0000); exp_ar_id_q.push_back(4'd0);
    exp_ifu_data_q.push_back(32'hDEAD_BEEF); exp_ifu_err_q.push_back(1'b0);
    start = cyc + 1;
    run_bus(12);
    tests_run++;
    if (obs_ar_addr_q.size() != 1 || obs_ar_addr_q[0] !== exp_ar_addr_q[0] || obs_ar_id_q[0] !== exp_ar_id_q[0]) begin
      tests_failed++;
      $display("FAIL ifu_ar: got n=%0d addr=%h id=%h required addr=%h id=%h", obs_ar_addr_q.size(),
               (obs_ar_addr_q.size() != 0) ? obs_ar_addr_q[0] : '0,
               (obs_ar_id_q.size() != 0) ? obs_ar_id_q[0] : '0, exp_ar_addr_q[0], exp_ar_id_q[0]);
    end
    tests_run++;
    if (obs_ifu_ack_cyc_q.size() != 1 || obs_ar_cyc_q.size() != 1 ||
        obs_ar_cyc_q[0] != start + 1 || obs_ifu_ack_cyc_q[0] != start + 1) begin
      tests_failed++;
      $display("FAIL ifu_ack_timing: acks=%0d required 1 at cycle %0d", obs_ifu_ack_cyc_q.size(), start + 1);
    end
    tests_run++;
    if (obs_ifu_data_q.size() != 1 || obs_ifu_data_q[0] !== exp_ifu_data_q[0] ||
        obs_ifu_err_q[0] !== exp_ifu_err_q[0] || obs_lsu_data_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ifu_data: n=%0d data=%h required 1 x %h err 0", obs_ifu_data_q.size(),
               (obs_ifu_data_q.size() != 0) ? obs_ifu_data_q[0] : '0, exp_ifu_data_q[0]);
    end
    tests_run++;
    if (obs_beat_cyc_q.size() != 1 || obs_ifu_dv_cyc_q.size() != 1 ||
        obs_beat_cyc_q[0] != start + 4 || obs_ifu_dv_cyc_q[0] != start + 5) begin
      tests_failed++;
      $display("FAIL ifu_r_timing: beats=%0d dvs=%0d required beat at %0d and data_valid at %0d",
               obs_beat_cyc_q.size(), obs_ifu_dv_cyc_q.size(), start + 4, start + 5);
    end
    $display("[TB] ifu_only: ar=%0d acks=%0d dv=%0d", obs_ar_addr_q.size(), obs_ifu_ack_cyc_q.size(), obs_ifu_data_q.size());
  endtask

  task automatic test_tie();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      ifu_addr_q.push_back(32'h100); lsu_addr_q.push_back(32'h200);
      exp_ar_addr_q.push_back(32'h100); exp_ar_id_q.push_back(4'd0);
      exp_ar_addr_q.push_back(32'h200); exp_ar_id_q.push_back(4'd1);
    end
    for (int i = 0; i < 4; i++) begin
      resp_data_q.push_back(32'hA000_0000 + i); resp_resp_q.push_back(2'b00);
      if (i % 2 == 0) begin exp_ifu_data_q.push_back(32'hA000_0000 + i); exp_ifu_err_q.push_back(1'b0); end
      else begin exp_lsu_data_q.push_back(32'hA000_0000 + i); exp_lsu_err_q.push_back(1'b0); end
    end
    run_bus(40);
    tests_run++;
    if (obs_ar_addr_q.size() != exp_ar_addr_q.size()) begin
      tests_failed++;
      $display("FAIL tie_count: got %0d AR required %0d", obs_ar_addr_q.size(), exp_ar_addr_q.size());
    end
    while (exp_ar_addr_q.size() != 0 && obs_ar_addr_q.size() != 0) begin
      logic [ADDR_W-1:0] ea, oa; logic [ID_W-1:0] ei, oi;
      ea = exp_ar_addr_q.pop_front(); oa = obs_ar_addr_q.pop_front();
      ei = exp_ar_id_q.pop_front();   oi = obs_ar_id_q.pop_front();
      tests_run++;
      if (oa !== ea || oi !== ei) begin
        tests_failed++;
        $display("FAIL tie_order: got addr=%h id=%h required addr=%h id=%h", oa, oi, ea, ei);
      end
      $display("[TB] tie AR addr=%h id=%h", oa, oi);
    end
    tests_run++;
    if (obs_ifu_data_q.size() != 2 || obs_lsu_data_q.size() != 2 ||
        obs_ifu_data_q[1] !== exp_ifu_data_q[1] || obs_lsu_data_q[1] !== exp_lsu_data_q[1]) begin
      tests_failed++;
      $display("FAIL tie_data: ifu n=%0d lsu n=%0d required 2/2 with routed data", obs_ifu_data_q.size(), obs_lsu_data_q.size());
    end
    tests_run++;
    if (dual_cnt != 0) begin
      tests_failed++;
      $display("FAIL tie_exclusive: got %0d dual pulses required 0", dual_cnt);
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    ar_ready_delay = 4;
    lsu_addr_q.push_back(32'h3000_0040);
    resp_data_q.push_back(32'h1234_5678); resp_resp_q.push_back(2'b00);
    exp_ar_addr_q.push_back(32'h3000_0040); exp_ar_id_q.push_back(4'd1);
    run_bus(16);
    tests_run++;
    if (obs_hs_cyc_q.size() != 1 || obs_ar_cyc_q.size() != 1 || obs_hs_cyc_q[0] - obs_ar_cyc_q[0] != 4) begin
      tests_failed++;
      $display("FAIL bp_hold: hs=%0d valid_start=%0d required handshake 4 cycles after valid",
               (obs_hs_cyc_q.size() != 0) ? obs_hs_cyc_q[0] : -1, (obs_ar_cyc_q.size() != 0) ? obs_ar_cyc_q[0] : -1);
    end
    tests_run++;
    if (unstable_cnt != 0 || obs_ar_addr_q.size() != 1 || obs_ar_addr_q[0] !== exp_ar_addr_q[0] || obs_ar_id_q[0] !== exp_ar_id_q[0]) begin
      tests_failed++;
      $display("FAIL bp_stable: unstable=%0d n=%0d required 0 and addr=%h id=%h", unstable_cnt,
               obs_ar_addr_q.size(), exp_ar_addr_q[0], exp_ar_id_q[0]);
    end
    tests_run++;
    if (obs_lsu_ack_cyc_q.size() != 1 || bad_ack_cnt != 0 || obs_hs_cyc_q.size() != 1 ||
        obs_lsu_ack_cyc_q[0] != obs_hs_cyc_q[0]) begin
      tests_failed++;
      $display("FAIL bp_ack: acks=%0d bad=%0d required single ack on handshake cycle", obs_lsu_ack_cyc_q.size(), bad_ack_cnt);
    end
    $display("[TB] backpressure: acks=%0d unstable=%0d", obs_lsu_ack_cyc_q.size(), unstable_cnt);
  endtask

  task automatic test_cancel();
    clear_all();
    r_lat = 3;
    cancel_after_ack = 1;
    lsu_late_valid = 1; lsu_late_addr = 32'h600;
    ifu_addr_q.push_back(32'h500);
    resp_data_q.push_back(32'h1111_1111); resp_resp_q.push_back(2'b00);
    resp_data_q.push_back(32'h2222_2222); resp_resp_q.push_back(2'b00);
    exp_ar_addr_q.push_back(32'h500); exp_ar_addr_q.push_back(32'h600);
    exp_lsu_data_q.push_back(32'h2222_2222);
    run_bus(20);
    tests_run++;
    if (obs_ifu_data_q.size() != 0 || obs_beat_cyc_q.size() != 2) begin
      tests_failed++;
      $display("FAIL cancel_drop: ifu dv=%0d beats=%0d required 0 dv and 2 beats", obs_ifu_data_q.size(), obs_beat_cyc_q.size());
    end
    tests_run++;
    if (obs_ar_addr_q.size() != 2 || obs_ar_addr_q[1] !== exp_ar_addr_q[1] ||
        obs_ar_cyc_q.size() != 2 || obs_beat_cyc_q.size() == 0 || obs_ar_cyc_q[1] != obs_beat_cyc_q[0] + 2) begin
      tests_failed++;
      $display("FAIL cancel_next_grant: ar n=%0d required LSU %h ar_valid 2 cycles after beat", obs_ar_addr_q.size(), exp_ar_addr_q[1]);
    end
    tests_run++;
    if (obs_lsu_data_q.size() != 1 || obs_lsu_data_q[0] !== exp_lsu_data_q[0]) begin
      tests_failed++;
      $display("FAIL cancel_lsu_data: n=%0d required 1 x %h", obs_lsu_data_q.size(), exp_lsu_data_q[0]);
    end
    $display("[TB] cancel: ifu_dv=%0d lsu_dv=%0d", obs_ifu_data_q.size(), obs_lsu_data_q.size());
  endtask

  task automatic test_error();
    clear_all();
    lsu_addr_q.push_back(32'h700);
    resp_data_q.push_back(32'hBAD0_BAD0); resp_resp_q.push_back(2'b10);
    exp_lsu_data_q.push_back(32'hBAD0_BAD0); exp_lsu_err_q.push_back(1'b1);
    run_bus(10);
    tests_run++;
    if (obs_lsu_data_q.size() != 1 || obs_lsu_data_q[0] !== exp_lsu_data_q[0] ||
        obs_lsu_err_q[0] !== exp_lsu_err_q[0] || obs_ifu_data_q.size() != 0) begin
      tests_failed++;
      $display("FAIL lsu_err: n=%0d data=%h err=%b required %h err 1",
               obs_lsu_data_q.size(), (obs_lsu_data_q.size() != 0) ? obs_lsu_data_q[0] : '0,
               (obs_lsu_err_q.size() != 0) ? obs_lsu_err_q[0] : 1'b0, exp_lsu_data_q[0]);
    end
    $display("[TB] error: lsu_dv=%0d", obs_lsu_data_q.size());
  endtask

  task automatic test_reset_mid_r();
    clear_all();
    r_lat = 50;
    ifu_addr_q.push_back(32'h800);
    run_bus(4);
    tests_run++;
    if (biu_ext_r_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_r_setup: r_ready=%b required 1", biu_ext_r_ready);
    end
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    clear_all();
    #1;
    tests_run++;
    if ({biu_ext_ar_valid, biu_ext_r_ready, biu_ifu_data_valid, biu_lsu_data_valid, biu_lsu_rd_err} !== 5'b0 ||
        biu_ext_ar_addr !== '0 || biu_ext_ar_id !== '0 || biu_ifu_data !== '0 || biu_lsu_data !== '0) begin
      tests_failed++;
      $display("FAIL mid_r_reset: valid=%b rready=%b addr=%h lsu_data=%h required all zero",
               biu_ext_ar_valid, biu_ext_r_ready, biu_ext_ar_addr, biu_lsu_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ext_biu_r_valid = 1; ext_biu_r_last = 1; ext_biu_r_id = '0; ext_biu_r_data = 32'hFFFF_FFFF;
      #1;
      tests_run++;
      if (biu_ext_r_ready !== 1'b0 || biu_ifu_data_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stray_beat: r_ready=%b dv=%b required 0/0", biu_ext_r_ready, biu_ifu_data_valid);
      end
    end
    idle_inputs();
    ifu_addr_q.push_back(32'h900);
    resp_data_q.push_back(32'h0A0B_0C0D); resp_resp_q.push_back(2'b00);
    exp_ifu_data_q.push_back(32'h0A0B_0C0D);
    run_bus(10);
    tests_run++;
    if (obs_ifu_data_q.size() != 1 || obs_ifu_data_q[0] !== exp_ifu_data_q[0]) begin
      tests_failed++;
      $display("FAIL post_reset_read: n=%0d required 1 x %h", obs_ifu_data_q.size(), exp_ifu_data_q[0]);
    end
    $display("[TB] reset_mid_r: recovered dv=%0d", obs_ifu_data_q.size());
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    repeat (3) @(posedge clk);
    test_reset();
    test_ifu_only();
    test_tie();
    test_backpressure();
    test_cancel();
    test_error();
    test_reset_mid_r();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
